// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: one-channel-at-a-time lamp sequencer with fixed
// round-robin and demand-driven scheduling. Outputs decode from registers only.
module traffic_phase_ctrl #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 4,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     req,
    input  logic                mode,
    output logic [2*N_CH-1:0]   light,
    output logic [2:0]          active_ch,
    output logic                phase_done
);
    localparam int CUR_W = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_timer, w_timer_nxt;
    logic [CUR_W-1:0]  r_cur, w_cur_nxt;
    logic [N_CH-1:0]   r_pend;
    logic [N_CH-1:0]   w_grant;
    logic [N_CH-1:0]   w_others;
    logic              w_found;
    logic [CUR_W-1:0]  w_pick;
    logic [CUR_W-1:0]  w_rr;

    // Circular search of pending demand, starting just after the current channel
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = r_cur;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(r_cur) + k) % N_CH;
            if (!w_found && r_pend[idx]) begin
                w_found = 1'b1;
                w_pick  = CUR_W'(idx);
            end
        end
    end

    // Round-robin successor and "someone else is waiting" flag
    always_comb begin
        w_rr     = (r_cur == CUR_W'(N_CH-1)) ? '0 : r_cur + 1'b1;
        w_others = r_pend & ~(N_CH'(1) << r_cur);
    end

    // Next-state logic; mode only matters in IDLE and at the end of green
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cur_nxt   = r_cur;
        w_grant     = '0;
        case (r_state)
            IDLE: begin
                if (!mode || w_found) begin
                    w_cur_nxt   = mode ? w_pick : w_rr;
                    w_grant     = N_CH'(1) << w_cur_nxt;
                    w_timer_nxt = CNT_W'(GREEN_T - 1);
                    w_state_nxt = GREEN;
                end
            end
            GREEN: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else if (!(mode && w_others == '0)) begin
                    // green extension holds here while nobody else waits
                    w_timer_nxt = CNT_W'(YELLOW_T - 1);
                    w_state_nxt = YELLOW;
                end
            end
            YELLOW: begin
                if (r_timer != '0) w_timer_nxt = r_timer - 1'b1;
                else               w_state_nxt = ALLRED;
            end
            ALLRED:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, timer, current channel and demand latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_cur   <= CUR_W'(N_CH-1);
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_cur   <= w_cur_nxt;
            // a req in the grant cycle of its own channel is consumed
            r_pend  <= (r_pend | req) & ~w_grant;
        end
    end

    // Moore output decode
    always_comb begin
        light = '0;
        if (r_state == GREEN)  light[2*int'(r_cur) +: 2] = 2'b01;
        if (r_state == YELLOW) light[2*int'(r_cur) +: 2] = 2'b10;
        phase_done = (r_state == ALLRED);
        active_ch  = 3'(r_cur);
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;
    logic       clk = 1'b0;
    logic       rst, mode;
    logic [1:0] req;
    logic [3:0] light;
    logic [2:0] active_ch;
    logic       phase_done;

    logic       rst4, mode4;
    logic [3:0] req4;
    logic [7:0] light4;
    logic [2:0] active_ch4;
    logic       phase_done4;

    int total = 0;
    int bad   = 0;

    traffic_phase_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .light(light), .active_ch(active_ch), .phase_done(phase_done)
    );

    traffic_phase_ctrl #(.N_CH(4)) dut4 (
        .clk(clk), .rst(rst4), .req(req4), .mode(mode4),
        .light(light4), .active_ch(active_ch4), .phase_done(phase_done4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lamp safety: at most one non-red channel, code 11 never shown
    always @(negedge clk) begin
        int nr;
        logic ok;
        nr = 0; ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (light[2*i +: 2] != 2'b00) nr++;
            if (light[2*i +: 2] == 2'b11) ok = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (light4[2*i +: 2] == 2'b11) ok = 1'b0;
        end
        if (nr > 1) ok = 1'b0;
        nr = 0;
        for (int i = 0; i < 4; i++) if (light4[2*i +: 2] != 2'b00) nr++;
        if (nr > 1) ok = 1'b0;
        total++;
        assert (ok) else begin
            $display("FAIL lamp_safety light=%b light4=%b", light, light4);
            bad++;
        end
    end

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; req = 2'b00;
        step(); step();
        total++;
        if (light !== 4'b0000 || phase_done !== 1'b0 || active_ch !== 3'd1 || dut.r_pend !== 2'b00) begin
            $display("FAIL reset light=%b pd=%b act=%0d pend=%b want 0000/0/1/00",
                     light, phase_done, active_ch, dut.r_pend);
            bad++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] el;
        int p, ch;
        rst = 1'b1; mode = 1'b0; req = 2'b00;
        step();
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            step();
            p  = k % 12;
            ch = (k / 12) % 2;
            if (p < 8)       el = 4'b0001 << (2*ch);
            else if (p < 10) el = 4'b0010 << (2*ch);
            else             el = 4'b0000;
            total++;
            if (light !== el || phase_done !== (p == 10) || active_ch !== 3'(ch)) begin
                $display("FAIL rr k=%0d light=%b pd=%b act=%0d want %b/%0d/%0d",
                         k, light, phase_done, active_ch, el, (p == 10), ch);
                bad++;
            end
        end
    endtask

    task automatic test_demand_idle();
        rst = 1'b1; mode = 1'b1; req = 2'b00;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (light !== 4'b0000 || active_ch !== 3'd1 || phase_done !== 1'b0) begin
                $display("FAIL demand_idle k=%0d light=%b act=%0d pd=%b want 0000/1/0",
                         k, light, active_ch, phase_done);
                bad++;
            end
        end
    endtask

    // Continues from test_demand_idle: idle in mode 1, cur=1
    task automatic test_extension();
        req = 2'b10;
        step();
        req = 2'b00;
        total++;
        if (light !== 4'b0000) begin
            $display("FAIL ext_latency light=%b want 0000", light); bad++;
        end
        step();
        total++;
        if (light !== 4'b0100 || active_ch !== 3'd1) begin
            $display("FAIL ext_grant light=%b act=%0d want 0100/1", light, active_ch); bad++;
        end
        for (int k = 0; k < 18; k++) begin
            step();
            total++;
            if (light !== 4'b0100) begin
                $display("FAIL ext_hold k=%0d light=%b want 0100", k, light); bad++;
            end
        end
        req = 2'b01;
        step();
        req = 2'b00;
        total++;
        if (light !== 4'b0100) begin
            $display("FAIL ext_pend_edge light=%b want 0100", light); bad++;
        end
        step();
        total++;
        if (light !== 4'b1000) begin
            $display("FAIL ext_yellow0 light=%b want 1000", light); bad++;
        end
        step();
        total++;
        if (light !== 4'b1000) begin
            $display("FAIL ext_yellow1 light=%b want 1000", light); bad++;
        end
        step();
        total++;
        if (light !== 4'b0000 || phase_done !== 1'b1) begin
            $display("FAIL ext_allred light=%b pd=%b want 0000/1", light, phase_done); bad++;
        end
        step();
        total++;
        if (light !== 4'b0000 || phase_done !== 1'b0) begin
            $display("FAIL ext_idle light=%b pd=%b want 0000/0", light, phase_done); bad++;
        end
        step();
        total++;
        if (light !== 4'b0001 || active_ch !== 3'd0) begin
            $display("FAIL ext_next light=%b act=%0d want 0001/0", light, active_ch); bad++;
        end
    endtask

    task automatic test_reset_yellow();
        rst = 1'b1; mode = 1'b0; req = 2'b00;
        step();
        rst = 1'b0; req = 2'b11;
        step();
        total++;
        if (dut.r_pend !== 2'b10) begin
            $display("FAIL grant_cycle_pend pend=%b want 10", dut.r_pend); bad++;
        end
        step();
        total++;
        if (dut.r_pend !== 2'b11) begin
            $display("FAIL later_pend pend=%b want 11", dut.r_pend); bad++;
        end
        for (int k = 0; k < 7; k++) step();
        total++;
        if (light !== 4'b0010) begin
            $display("FAIL pre_reset_yellow light=%b want 0010", light); bad++;
        end
        rst = 1'b1;
        step();
        total++;
        if (light !== 4'b0000 || phase_done !== 1'b0 || dut.r_pend !== 2'b00 || active_ch !== 3'd1) begin
            $display("FAIL reset_in_yellow light=%b pd=%b pend=%b act=%0d want 0000/0/00/1",
                     light, phase_done, dut.r_pend, active_ch);
            bad++;
        end
        rst = 1'b0; req = 2'b00;
        step();
        total++;
        if (light !== 4'b0001 || active_ch !== 3'd0) begin
            $display("FAIL post_reset_grant light=%b act=%0d want 0001/0", light, active_ch); bad++;
        end
    endtask

    task automatic test_four_ch();
        int order[4];
        int n, g;
        logic prev_green;
        rst4 = 1'b1; mode4 = 1'b0; req4 = 4'b0000;
        step();
        rst4 = 1'b0;
        for (int k = 0; k < 14; k++) step();
        total++;
        if (light4 !== 8'b0000_0100 || active_ch4 !== 3'd1) begin
            $display("FAIL four_setup light4=%b act=%0d want 00000100/1", light4, active_ch4); bad++;
        end
        mode4 = 1'b1; req4 = 4'b1010;
        n = 0; prev_green = 1'b1;
        for (int c = 0; c < 80 && n < 4; c++) begin
            step();
            g = -1;
            for (int i = 0; i < 4; i++) if (light4[2*i +: 2] == 2'b01) g = i;
            if (g == 0 || g == 2) begin
                total++;
                $display("FAIL four_bad_green ch=%0d want 1 or 3", g); bad++;
            end
            if (g >= 0 && !prev_green) begin
                order[n] = g;
                n++;
            end
            prev_green = (g >= 0);
        end
        total++;
        if (n !== 4) begin
            $display("FAIL four_timeout grants=%0d want 4", n); bad++;
        end else begin
            total++;
            if (order[0] != 3 || order[1] != 1 || order[2] != 3 || order[3] != 1) begin
                $display("FAIL four_order got %0d,%0d,%0d,%0d want 3,1,3,1",
                         order[0], order[1], order[2], order[3]);
                bad++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; req = 2'b00;
        rst4 = 1'b1; mode4 = 1'b0; req4 = 4'b0000;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_demand_idle();
        test_extension();
        test_reset_yellow();
        test_four_ch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
